// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolution: evaluates branch conditions, registers the
// redirect/target/link, holds a flush window toward IF/ID and keeps statistics.
module branch_resolve_unit #(
  parameter int XLEN           = 32,
  parameter int FLUSH_CYCLES   = 2,
  parameter int CNT_W          = 32,
  parameter int ALIGN_MASK_LSB = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             stall,
  input  logic             is_branch,
  input  logic             is_jal,
  input  logic             is_jalr,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  output logic             redirect,
  output logic [XLEN-1:0]  target,
  output logic [XLEN-1:0]  link,
  output logic             flush,
  output logic             illegal,
  output logic             misalign,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic {IDLE, FLUSH} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_BRANCH, OP_JAL, OP_JALR} op_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  state_t          state_q, state_d;
  logic [3:0]      fcnt_q, fcnt_d;
  op_t             op;
  logic            accept;
  logic            cond_true;
  logic            bad_f3;
  logic            taken;
  logic            is_jump;
  logic            br_illegal;
  logic            tgt_misaligned;
  logic            do_redirect;
  logic [XLEN-1:0] pc_target;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] jalr_target;
  logic [XLEN-1:0] sel_target;
  logic [XLEN-1:0] link_next;

  assign accept = valid_in & ~stall & (state_q == IDLE);

  // Type priority when several flags are set: JALR > JAL > branch.
  always_comb begin
    if (is_jalr)        op = OP_JALR;
    else if (is_jal)    op = OP_JAL;
    else if (is_branch) op = OP_BRANCH;
    else                op = OP_NONE;
  end

  // NOTE: every variable written in a combinational block gets a default
  // first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    cond_true = 1'b0;
    bad_f3    = 1'b0;
    unique case (funct3)
      3'b000:  cond_true = (rs1 == rs2);
      3'b001:  cond_true = (rs1 != rs2);
      3'b100:  cond_true = ($signed(rs1) <  $signed(rs2));
      3'b101:  cond_true = ($signed(rs1) >= $signed(rs2));
      3'b110:  cond_true = (rs1 <  rs2);
      3'b111:  cond_true = (rs1 >= rs2);
      default: bad_f3    = 1'b1;
    endcase
  end

  // All sums wrap modulo 2^XLEN; JALR clears bit 0 of its sum.
  assign pc_target   = pc + imm;
  assign jalr_sum    = rs1 + imm;
  assign jalr_target = jalr_sum & ~XLEN'(1);
  assign link_next   = pc + XLEN'(4);

  always_comb begin
    taken      = 1'b0;
    is_jump    = 1'b0;
    br_illegal = 1'b0;
    sel_target = pc_target;
    unique case (op)
      OP_JALR: begin
        taken      = 1'b1;
        is_jump    = 1'b1;
        sel_target = jalr_target;
      end
      OP_JAL: begin
        taken   = 1'b1;
        is_jump = 1'b1;
      end
      OP_BRANCH: begin
        taken      = cond_true;
        br_illegal = bad_f3;
      end
      default: ;
    endcase
  end

  // A misaligned taken target reports misalign instead of redirecting.
  assign tgt_misaligned = taken & (|sel_target[ALIGN_MASK_LSB-1:0]);
  assign do_redirect    = accept & taken & ~tgt_misaligned;

  // Flush window: entered with the redirect, counted down while not stalled.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      IDLE: begin
        if (do_redirect) begin
          state_d = FLUSH;
          fcnt_d  = FLUSH_INIT;
        end
      end
      FLUSH: begin
        if (!stall) begin
          if (fcnt_q <= 4'd1) begin
            state_d = IDLE;
            fcnt_d  = 4'd0;
          end else begin
            fcnt_d = fcnt_q - 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        fcnt_d  = 4'd0;
      end
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so all
  // registers sample the same pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      fcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign flush = (state_q == FLUSH);

  // Pulses are rewritten every cycle, so they drop after one cycle even under stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect <= 1'b0;
      illegal  <= 1'b0;
      misalign <= 1'b0;
      target   <= '0;
      link     <= '0;
    end else begin
      redirect <= do_redirect;
      illegal  <= accept & br_illegal;
      misalign <= accept & tgt_misaligned;
      if (accept && taken)   target <= sel_target;
      if (accept && is_jump) link   <= link_next;
    end
  end

  // Saturating statistics counters for conditional branches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else if (accept && op == OP_BRANCH) begin
      if (!(&branch_cnt))         branch_cnt <= branch_cnt + CNT_W'(1);
      if (taken && !(&taken_cnt)) taken_cnt  <= taken_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench: two DUT configurations driven in lockstep, each compared
// cycle by cycle against a transaction-level reference model via a scoreboard.
module tb_branch_resolve_unit;

  typedef struct {
    int          flush_left;
    longint      bc;
    longint      tc;
    logic [31:0] link;
  } mstate_t;

  typedef struct {
    bit          redirect;
    logic [31:0] target;
    bit          illegal;
    bit          misalign;
    bit          flush;
    logic [31:0] link;
    longint      bc;
    longint      tc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, stall, is_branch, is_jal, is_jalr;
  logic [2:0]  funct3;
  logic [31:0] pc, imm, rs1, rs2;

  logic        a_redirect, a_flush, a_illegal, a_misalign;
  logic [31:0] a_target, a_link, a_branch_cnt, a_taken_cnt;
  logic        b_redirect, b_flush, b_illegal, b_misalign;
  logic [31:0] b_target, b_link;
  logic [3:0]  b_branch_cnt, b_taken_cnt;

  int checks = 0;
  int errors = 0;

  mstate_t sa, sb;
  exp_t    qa[$];
  exp_t    qb[$];

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(32), .ALIGN_MASK_LSB(1)) dut_a (
    .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .funct3(funct3),
    .pc(pc), .imm(imm), .rs1(rs1), .rs2(rs2),
    .redirect(a_redirect), .target(a_target), .link(a_link), .flush(a_flush),
    .illegal(a_illegal), .misalign(a_misalign),
    .branch_cnt(a_branch_cnt), .taken_cnt(a_taken_cnt)
  );

  branch_resolve_unit #(.XLEN(32), .FLUSH_CYCLES(3), .CNT_W(4), .ALIGN_MASK_LSB(2)) dut_b (
    .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .funct3(funct3),
    .pc(pc), .imm(imm), .rs1(rs1), .rs2(rs2),
    .redirect(b_redirect), .target(b_target), .link(b_link), .flush(b_flush),
    .illegal(b_illegal), .misalign(b_misalign),
    .branch_cnt(b_branch_cnt), .taken_cnt(b_taken_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: one clock edge of the resolution stage, from the architectural rules.
  task automatic model_step(input mstate_t s_in, input int fc, input int cnt_w, input int align,
                            output mstate_t s_out, output exp_t e);
    mstate_t     s;
    bit          take, jump, br;
    logic [31:0] t;
    longint      cmax;
    s    = s_in;
    cmax = (longint'(1) << cnt_w) - 1;
    e.redirect = 0; e.illegal = 0; e.misalign = 0; e.target = '0;
    if (s.flush_left > 0) begin
      if (!stall) s.flush_left--;
    end else if (valid_in && !stall) begin
      take = 0; jump = 0; br = 0;
      t = pc + imm;
      if (is_jalr) begin
        take = 1; jump = 1;
        t = rs1 + imm;
        t = t & 32'hFFFF_FFFE;
      end else if (is_jal) begin
        take = 1; jump = 1;
      end else if (is_branch) begin
        br = 1;
        case (funct3)
          3'd0: take = (rs1 == rs2);
          3'd1: take = (rs1 != rs2);
          3'd4: take = ($signed(rs1) <  $signed(rs2));
          3'd5: take = ($signed(rs1) >= $signed(rs2));
          3'd6: take = (rs1 <  rs2);
          3'd7: take = (rs1 >= rs2);
          default: e.illegal = 1;
        endcase
      end
      if (jump) s.link = pc + 32'd4;
      if (br) begin
        if (s.bc < cmax) s.bc++;
        if (take && s.tc < cmax) s.tc++;
      end
      if (take) begin
        if ((t % (32'd1 << align)) != 0) e.misalign = 1;
        else begin
          e.redirect = 1;
          e.target   = t;
          s.flush_left = fc;
        end
      end
    end
    e.flush = (s.flush_left > 0);
    e.link  = s.link;
    e.bc    = s.bc;
    e.tc    = s.tc;
    s_out   = s;
  endtask

  // Drive one cycle of stimulus, push both expectations, then advance to the
  // sampling point after the following falling edge.
  task automatic drive(input bit v, input bit st, input bit br, input bit jl, input bit jr,
                       input logic [2:0] f3, input logic [31:0] p, input logic [31:0] im,
                       input logic [31:0] r1, input logic [31:0] r2);
    exp_t ea, eb;
    valid_in = v; stall = st; is_branch = br; is_jal = jl; is_jalr = jr;
    funct3 = f3; pc = p; imm = im; rs1 = r1; rs2 = r2;
    model_step(sa, 2, 32, 1, sa, ea);
    model_step(sb, 3, 4, 2, sb, eb);
    qa.push_back(ea);
    qb.push_back(eb);
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic reset_model();
    sa = '{flush_left: 0, bc: 0, tc: 0, link: 32'h0};
    sb = '{flush_left: 0, bc: 0, tc: 0, link: 32'h0};
    qa.delete();
    qb.delete();
  endtask

  // Monitor: pops one expectation per cycle and compares both instances.
  always @(negedge clk) begin
    exp_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      check("A.redirect", 32'(a_redirect), 32'(e.redirect));
      if (e.redirect) check("A.target", a_target, e.target);
      check("A.illegal", 32'(a_illegal), 32'(e.illegal));
      check("A.misalign", 32'(a_misalign), 32'(e.misalign));
      check("A.flush", 32'(a_flush), 32'(e.flush));
      check("A.link", a_link, e.link);
      check("A.branch_cnt", a_branch_cnt, 32'(e.bc));
      check("A.taken_cnt", a_taken_cnt, 32'(e.tc));
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      check("B.redirect", 32'(b_redirect), 32'(e.redirect));
      if (e.redirect) check("B.target", b_target, e.target);
      check("B.illegal", 32'(b_illegal), 32'(e.illegal));
      check("B.misalign", 32'(b_misalign), 32'(e.misalign));
      check("B.flush", 32'(b_flush), 32'(e.flush));
      check("B.link", b_link, e.link);
      check("B.branch_cnt", 32'(b_branch_cnt), 32'(e.bc));
      check("B.taken_cnt", 32'(b_taken_cnt), 32'(e.tc));
    end
  end

  initial begin
    rst = 1'b1;
    valid_in = 0; stall = 0; is_branch = 0; is_jal = 0; is_jalr = 0;
    funct3 = 3'd0; pc = '0; imm = '0; rs1 = '0; rs2 = '0;
    reset_model();
    repeat (2) @(negedge clk);
    #1;
    check("reset.a_redirect", 32'(a_redirect), 32'd0);
    check("reset.a_flush", 32'(a_flush), 32'd0);
    check("reset.a_branch_cnt", a_branch_cnt, 32'd0);
    check("reset.b_link", b_link, 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;

    // BEQ taken: target 0x120, flush window follows.
    drive(1, 0, 1, 0, 0, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5);
    idle(4);
    // BLT taken vs BLTU not taken for -1 against 1.
    drive(1, 0, 1, 0, 0, 3'b100, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1);
    idle(4);
    drive(1, 0, 1, 0, 0, 3'b110, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1);
    idle(1);
    // JALR to 0x1006 (misaligned for the IALIGN32 instance), then a squashed BEQ.
    drive(1, 0, 0, 0, 1, 3'b000, 32'h200, 32'd4, 32'h1003, 32'd0);
    drive(1, 0, 1, 0, 0, 3'b000, 32'h400, 32'h10, 32'd7, 32'd7);
    idle(4);
    // Illegal funct3 and a misaligned JAL target.
    drive(1, 0, 1, 0, 0, 3'b010, 32'h500, 32'h8, 32'd1, 32'd1);
    drive(1, 0, 0, 1, 0, 3'b000, 32'h100, 32'h3, 32'd0, 32'd0);
    idle(1);
    // Priority: all flags set resolves as JALR.
    drive(1, 0, 1, 1, 1, 3'b001, 32'h600, 32'h10, 32'h2000, 32'h2000);
    idle(4);
    // Stall held for three cycles inside the flush window.
    drive(1, 0, 1, 0, 0, 3'b000, 32'h700, 32'h40, 32'd3, 32'd3);
    for (int i = 0; i < 3; i++) drive(1, 1, 1, 0, 0, 3'b000, 32'h800, 32'h4, 32'd1, 32'd1);
    idle(4);

    // Asynchronous reset in the middle of a flush window.
    drive(1, 0, 1, 0, 0, 3'b001, 32'h900, 32'h20, 32'd1, 32'd2);
    idle(1);
    rst = 1'b1;
    #1;
    check("midreset.a_flush", 32'(a_flush), 32'd0);
    check("midreset.b_flush", 32'(b_flush), 32'd0);
    check("midreset.a_branch_cnt", a_branch_cnt, 32'd0);
    check("midreset.a_taken_cnt", a_taken_cnt, 32'd0);
    check("midreset.b_branch_cnt", 32'(b_branch_cnt), 32'd0);
    check("midreset.a_link", a_link, 32'd0);
    reset_model();
    @(negedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;

    // Saturation: 20 taken BNEs on the 4-bit-counter instance.
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 1, 0, 0, 3'b001, 32'h1000 + 32'(i * 16), 32'h40, 32'(i), 32'(i + 1));
      idle(3);
    end
    check("sat.b_branch_cnt", 32'(b_branch_cnt), 32'd15);
    check("sat.b_taken_cnt", 32'(b_taken_cnt), 32'd15);
    check("sat.a_branch_cnt", a_branch_cnt, 32'd20);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] r1, r2, p, im;
      logic [2:0]  fl;
      r1 = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3)) - 32'd1;
      r2 = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3)) - 32'd1;
      p  = ($urandom_range(0, 4) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      im = ($urandom_range(0, 2) == 0) ? $urandom : 32'($signed($urandom_range(0, 255)) - 128);
      fl = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b001 << $urandom_range(0, 2);
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2, fl[0], fl[1], fl[2],
            3'($urandom), p, im, r1, r2);
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Registered, parametrised branch/jump resolution stage for the EX stage of the pipelined RV32 core.
- Evaluates all six conditional branches plus JAL/JALR and computes the redirect target (PC+imm, or (rs1+imm)&~1) and the link value PC+4.
- Drives a one-cycle redirect pulse and a multi-cycle flush window toward IF/ID.
- Flags illegal funct3 and misaligned targets, and keeps branch/taken statistics counters.

Parameters:
XLEN, 32, datapath width for PC, immediate, operands and targets.
FLUSH_CYCLES, 2, number of cycles flush stays asserted after a redirect (1..15).
CNT_W, 32, width of the statistics counters.
ALIGN_MASK_LSB, 1, number of target LSBs that must be zero (1 = IALIGN16, 2 = IALIGN32).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
valid_in  in  1  EX-stage instruction valid.
stall  in  1  hold: stage registers, FSM and counters freeze.
is_branch  in  1  conditional branch (B-type).
is_jal  in  1  JAL.
is_jalr  in  1  JALR.
funct3  in  3  branch condition select.
pc  in  XLEN  instruction PC.
imm  in  XLEN  sign-extended immediate.
rs1  in  XLEN  operand 1.
rs2  in  XLEN  operand 2.
redirect  out  1  one-cycle pulse: fetch must load target.
target  out  XLEN  redirect address, valid while redirect=1.
link  out  XLEN  PC+4 of the last resolved jump.
flush  out  1  squash younger instructions.
illegal  out  1  one-cycle pulse: funct3 is 010 or 011 on is_branch.
misalign  out  1  one-cycle pulse: taken target has nonzero masked LSBs.
branch_cnt  out  CNT_W  resolved conditional branches.
taken_cnt  out  CNT_W  taken conditional branches.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, flush counter 0. Reset is asynchronous and valid mid-flush, aborting the window immediately.
- Accept condition: valid_in & ~stall & state==IDLE. Inputs arriving during FLUSH are squashed: no outputs and no counting.
- Conditions:
  - 000 EQ, 001 NE.
  - 100 LT and 101 GE, compared as signed.
  - 110 LTU and 111 GEU, compared as unsigned.
  - 010 and 011 are illegal: pulse illegal, not taken, counted in branch_cnt.
- Jumps: JAL and JALR are always taken. JAL target = pc+imm; JALR target = (rs1+imm) with bit0 cleared. Both register link = pc+4.
- Priority when more than one type flag is set: is_jalr > is_jal > is_branch.
- Arithmetic: all sums are modulo 2^XLEN and wrap silently.
- Latency:
  - Resolution is registered. redirect, target, illegal and misalign are asserted on the edge after acceptance, for exactly one cycle.
  - link holds its value until the next jump.
- Misaligned target (target[ALIGN_MASK_LSB-1:0] != 0 on a taken branch or jump):
  - Pulse misalign, suppress redirect, do not enter FLUSH.
  - Taken still counts in taken_cnt for branches.
- FSM IDLE -> FLUSH when redirect is issued. flush is asserted in the same cycle as redirect and for FLUSH_CYCLES cycles total, counted with a 4-bit down-counter.
- FLUSH -> IDLE when the counter reaches 1 and ~stall. stall freezes the counter while keeping flush asserted.
- Counters: branch_cnt increments on each accepted is_branch; taken_cnt increments on each taken is_branch. Both saturate at all-ones and do not wrap.
- stall=1 in IDLE: no acceptance. Pulse outputs return to 0 after one cycle regardless of stall.

Test Plan:
- BEQ: rs1=5, rs2=5, pc=0x100, imm=0x20 -> next cycle redirect=1, target=0x120, flush high 2 cycles; branch_cnt=1, taken_cnt=1.
- BLT vs BLTU: rs1=0xFFFFFFFF, rs2=1. BLT is taken; BLTU is not taken (no redirect, flush=0, taken_cnt unchanged).
- JALR: rs1=0x1003, imm=4, pc=0x200 -> target=0x1006, link=0x204, redirect one cycle. A valid_in in the following cycle is squashed: counters unchanged.
- Illegal and misalign:
  - funct3=010 -> illegal pulse, branch_cnt increments, no redirect.
  - JAL with pc=0x100, imm=0x3, ALIGN_MASK_LSB=2 -> misalign pulse, no redirect, no flush.
- Stall and reset mid-flush: during FLUSH hold stall=1 for 3 cycles -> flush stays 1 and the window extends by 3. Asserting rst mid-window clears flush and all counters asynchronously.
- Saturation: CNT_W=4, issue 20 taken BNEs -> branch_cnt=taken_cnt=15.
